bin_to_bcd_seq: RTL and testbench

//  Sequential double-dabble converter: turns a binary value into packed BCD digits.

---
 rtl/seg_pkg.sv | 24 ++
 rtl/bin_to_bcd_seq_if.sv | 15 +
 rtl/bcd_add3.sv | 8 +
 rtl/bin_to_bcd_seq.sv | 108 ++++++++++
 tb/tb_bin_to_bcd_seq.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the binary-to-BCD converter feeding the
// segment display path.
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int DIGITS_DEF = 4;
    localparam int BCD_W      = 4 * DIGITS_DEF;

    // Largest value representable in 'digits' decimal digits (10**digits - 1).
    function automatic logic [63:0] maxval(input int digits);
        logic [63:0] v;
        v = 64'd1;
        for (int i = 0; i < digits; i++) begin
            v = v * 64'd10;
        end
        return v - 64'd1;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Start/busy/done handshake plus data buses of the binary-to-BCD converter.
interface bin_to_bcd_seq_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 4
);
    logic                  start;
    logic [WIDTH-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  overflow;

    modport master (output start, bin, input busy, done, bcd, overflow);
    modport slave  (input start, bin, output busy, done, bcd, overflow);
endinterface

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets 3 added
// so the following left shift carries correctly into the next digit.
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);
    assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one input bit per clock, fixed
// WIDTH+1 edge latency, saturating to all-9s when the value does not fit.
module bin_to_bcd_seq
    import seg_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 4
) (
    input  logic            clock,
    input  logic            reset_n,
    bin_to_bcd_seq_if.slave io
);

    localparam int          BW    = 4 * DIGITS;
    localparam int          CNT_W = $clog2(WIDTH);
    localparam logic [63:0] MAXV  = maxval(DIGITS);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   bin_q, bin_d;
    logic [BW-1:0]      scr_q, scr_d;
    logic [BW-1:0]      adj, scr_sh;
    logic [WIDTH-1:0]   bin_sh;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]      bcd_q, bcd_d;
    logic               ovf_pend_q, ovf_pend_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (scr_q[4*g +: 4]),
            .dout (adj[4*g +: 4])
        );
    end

    assign scr_sh = {adj[BW-2:0], bin_q[WIDTH-1]};
    assign bin_sh = {bin_q[WIDTH-2:0], 1'b0};

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        scr_d      = scr_q;
        cnt_d      = cnt_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        ovf_pend_d = ovf_pend_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (io.start) begin
                    state_d    = SHIFT;
                    bin_d      = io.bin;
                    scr_d      = '0;
                    cnt_d      = CNT_W'(WIDTH - 1);
                    // Overflow is judged on the captured value; scratch only
                    // holds DIGITS digits and is discarded in that case.
                    ovf_pend_d = 64'(io.bin) > MAXV;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                scr_d = scr_sh;
                bin_d = bin_sh;
                if (cnt_q == '0) begin
                    state_d = DONE;
                    bcd_d   = ovf_pend_q ? {DIGITS{4'h9}} : scr_sh;
                    ovf_d   = ovf_pend_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            scr_q      <= '0;
            cnt_q      <= '0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            ovf_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            scr_q      <= scr_d;
            cnt_q      <= cnt_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
            ovf_pend_q <= ovf_pend_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign io.busy     = busy_q;
    assign io.done     = done_q;
    assign io.bcd      = bcd_q;
    assign io.overflow = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: directed table, handshake corner
// cases and a random sweep against a decimal-arithmetic reference.
module tb_bin_to_bcd_seq;
    import seg_pkg::*;

    localparam int WIDTH  = 16;
    localparam int DIGITS = DIGITS_DEF;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    bin_to_bcd_seq_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

    bin_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .io      (bus)
    );

    typedef struct {
        logic [15:0] bin;
        logic [15:0] bcd;
        logic        ovf;
    } vec_t;

    vec_t tbl[12];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain decimal digit extraction, saturating above 9999.
    function automatic logic [16:0] ref_conv(input int v);
        logic [15:0] b;
        int          t;
        if (v > 9999) return {1'b1, 16'h9999};
        t = v;
        b = '0;
        for (int i = 0; i < 4; i++) begin
            b[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return {1'b0, b};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Launch one conversion; return edges from accept to done and busy cycles.
    task automatic run_conv(input logic [15:0] v, output int lat, output int bsy);
        bus.bin   = v;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.bin   = 16'($urandom);
        lat = 0;
        bsy = 0;
        while (!bus.done && lat < 40) begin
            if (bus.busy) bsy++;
            step();
            lat++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          lat, bsy, ndone;
        logic [15:0] got, v;
        logic [16:0] exp;

        tbl[0]  = '{16'd10,    16'h0010, 1'b0};
        tbl[1]  = '{16'd0,     16'h0000, 1'b0};
        tbl[2]  = '{16'd9999,  16'h9999, 1'b0};
        tbl[3]  = '{16'd1234,  16'h1234, 1'b0};
        tbl[4]  = '{16'd10000, 16'h9999, 1'b1};
        tbl[5]  = '{16'd65535, 16'h9999, 1'b1};
        tbl[6]  = '{16'd1,     16'h0001, 1'b0};
        tbl[7]  = '{16'd9,     16'h0009, 1'b0};
        tbl[8]  = '{16'd99,    16'h0099, 1'b0};
        tbl[9]  = '{16'd100,   16'h0100, 1'b0};
        tbl[10] = '{16'd5000,  16'h5000, 1'b0};
        tbl[11] = '{16'd8765,  16'h8765, 1'b0};

        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.bin   = '0;
        repeat (3) step();
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_bcd",  32'(bus.bcd),  32'd0);
        check("reset_ovf",  32'(bus.overflow), 32'd0);
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 12; i++) begin
            run_conv(tbl[i].bin, lat, bsy);
            check($sformatf("tbl%0d_latency", i), 32'(lat), 32'(WIDTH));
            check($sformatf("tbl%0d_busy", i), 32'(bsy), 32'(WIDTH));
            check($sformatf("tbl%0d_bcd", i), 32'(bus.bcd), 32'(tbl[i].bcd));
            check($sformatf("tbl%0d_ovf", i), 32'(bus.overflow), 32'(tbl[i].ovf));
            step();
            check($sformatf("tbl%0d_done_pulse", i), 32'(bus.done), 32'd0);
            check($sformatf("tbl%0d_bcd_hold", i), 32'(bus.bcd), 32'(tbl[i].bcd));
        end

        // start pulses mid-conversion must be ignored
        bus.bin   = 16'd1234;
        bus.start = 1'b1;
        step();
        ndone = 0;
        got   = '0;
        for (int k = 1; k <= 30; k++) begin
            bus.start = (k == 3 || k == 8);
            bus.bin   = 16'd5555;
            step();
            if (bus.done) begin
                ndone++;
                got = bus.bcd;
            end
        end
        bus.start = 1'b0;
        check("ignore_start_ndone", 32'(ndone), 32'd1);
        check("ignore_start_bcd", 32'(got), 32'h1234);

        // back-to-back: start held through DONE
        bus.bin   = 16'd99;
        bus.start = 1'b1;
        step();
        bus.bin = 16'd42;
        lat = 0;
        while (!bus.done && lat < 40) begin
            step();
            lat++;
        end
        check("b2b_first_latency", 32'(lat), 32'(WIDTH));
        check("b2b_first_bcd", 32'(bus.bcd), 32'h0099);
        step();
        bus.start = 1'b0;
        bus.bin   = 16'd7777;
        check("b2b_restart_busy", 32'(bus.busy), 32'd1);
        check("b2b_restart_done", 32'(bus.done), 32'd0);
        lat = 1;
        while (!bus.done && lat < 40) begin
            step();
            lat++;
        end
        check("b2b_second_latency", 32'(lat), 32'(WIDTH + 1));
        check("b2b_second_bcd", 32'(bus.bcd), 32'h0042);
        step();

        // async reset mid-conversion
        bus.bin   = 16'd4321;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (7) step();
        #2 reset_n = 1'b0;
        #1;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_bcd",  32'(bus.bcd),  32'd0);
        check("midrst_ovf",  32'(bus.overflow), 32'd0);
        repeat (2) step();
        reset_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 25; k++) begin
            step();
            if (bus.done) ndone++;
        end
        check("midrst_no_done", 32'(ndone), 32'd0);
        run_conv(16'd7, lat, bsy);
        check("after_rst_latency", 32'(lat), 32'(WIDTH));
        check("after_rst_bcd", 32'(bus.bcd), 32'h0007);
        check("after_rst_ovf", 32'(bus.overflow), 32'd0);
        step();

        // random sweep against the decimal reference
        for (int n = 0; n < 1000; n++) begin
            if ($urandom_range(0, 1) == 1) v = 16'($urandom_range(0, 9999));
            else                           v = 16'($urandom_range(0, 65535));
            exp = ref_conv(int'(v));
            run_conv(v, lat, bsy);
            check($sformatf("rnd%0d_latency(bin=%0d)", n, v), 32'(lat), 32'(WIDTH));
            check($sformatf("rnd%0d_bcd(bin=%0d)", n, v), 32'(bus.bcd), 32'(exp[15:0]));
            check($sformatf("rnd%0d_ovf(bin=%0d)", n, v), 32'(bus.overflow), 32'(exp[16]));
            if ($urandom_range(0, 3) == 0) step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
